// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_cneg.sv
// Conditional two's-complement negate: y_c = neg ? -x : x.
module mdu_cneg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y_c
);

    assign y_c = neg ? ((~x) + WIDTH'(1)) : x;

endmodule

// File: rtl/mdu_iter.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Optional MDU_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned DW    = 2 * WIDTH;

    mdu_state_e state, state_nxt;
    logic load, step, fix_wr, last;

    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    acc;     // mul: product; div: {remainder, quotient}
    logic [DW-1:0]    mc;      // mul: shifted multiplicand; div: divisor in low half
    logic [WIDTH-1:0] mp;      // remaining multiplier bits
    logic             is_div, sign_q, sign_r;

    logic             signed_op, is_div_op, b_zero;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   div_sh, div_diff;
    logic [DW-1:0]    div_nxt, mul_nxt, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign signed_op = ~op[0];
    assign is_div_op = op[1];
    assign b_zero    = (b == '0);

    mdu_cneg #(.WIDTH(WIDTH)) u_abs_a (.neg(signed_op & a[WIDTH-1]), .x(a), .y_c(abs_a));
    mdu_cneg #(.WIDTH(WIDTH)) u_abs_b (.neg(signed_op & b[WIDTH-1]), .x(b), .y_c(abs_b));

    mdu_cneg #(.WIDTH(DW))    u_fix_p (.neg(sign_q), .x(acc),             .y_c(prod_fix));
    mdu_cneg #(.WIDTH(WIDTH)) u_fix_q (.neg(sign_q), .x(acc[WIDTH-1:0]),  .y_c(quo_fix));
    mdu_cneg #(.WIDTH(WIDTH)) u_fix_r (.neg(sign_r), .x(acc[DW-1:WIDTH]), .y_c(rem_fix));

    // Restoring division step: shift in next dividend bit, subtract if it fits
    assign div_sh   = acc[DW-1:WIDTH-1];
    assign div_diff = div_sh - {1'b0, mc[WIDTH-1:0]};
    assign div_nxt  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign mul_nxt  = mp[0] ? (acc + mc) : acc;

`ifdef MDU_EARLY_OUT_EN
    assign last = (cnt == CNT_W'(1)) || (!is_div && (mp[WIDTH-1:1] == '0));
`else
    assign last = (cnt == CNT_W'(1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fix_wr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_nxt = ST_RUN;
                    load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        state_nxt = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_nxt = ST_IDLE;
                fix_wr    = !flush;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath, HI/LO and registered status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            mc     <= '0;
            mp     <= '0;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (load) begin
                cnt    <= CNT_W'(WIDTH);
                acc    <= is_div_op ? {{WIDTH{1'b0}}, abs_a} : '0;
                mc     <= is_div_op ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
                mp     <= abs_b;
                is_div <= is_div_op;
                // Divide-by-zero keeps the all-ones quotient unsigned
                sign_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]) & ~(is_div_op & b_zero);
                sign_r <= signed_op & a[WIDTH-1];
            end else if (step) begin
                cnt <= cnt - CNT_W'(1);
                if (is_div) begin
                    acc <= div_nxt;
                end else begin
                    acc <= mul_nxt;
                    mc  <= {mc[DW-2:0], 1'b0};
                    mp  <= {1'b0, mp[WIDTH-1:1]};
                end
            end

            if (fix_wr) begin
                hi <= is_div ? rem_fix : prod_fix[DW-1:WIDTH];
                lo <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
            end else if (state == ST_IDLE) begin
                if (hi_wr) hi <= wdata;
                if (lo_wr) lo <= wdata;
            end

            busy <= (state_nxt != ST_IDLE);
            done <= fix_wr;
        end
    end

endmodule
